// File: rtl/timer_counter.sv
// 8-bit up/down timer count register with sticky overflow/underflow flags.
// The counting core lives in module `counter`; timer_counter is the top-level
// wrapper that exposes it. A wrap is first captured in a one-cycle event
// register, so a flag goes high one edge after the wrapping edge.

module counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ena,
    input  logic [7:0] start_counter,
    input  logic       up_down,
    input  logic       load,
    input  logic       enable,
    input  logic       clr_overflow,
    input  logic       clr_underflow,
    output logic       overflow,
    output logic       underflow
);

    logic [7:0] reg_TCNT;
    logic       r_ovf_evt;
    logic       r_unf_evt;
    logic       w_tick;
    logic       w_tick_up;
    logic       w_tick_dn;

    // Load has priority over counting, so a tick only counts while load is low.
    assign w_tick    = enable && clk_ena && !load;
    assign w_tick_up = w_tick && up_down;
    assign w_tick_dn = w_tick && !up_down;

    // Count register: load beats counting, and it holds when there is no tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_TCNT <= 8'h00;
        end else if (load) begin
            reg_TCNT <= start_counter;
        end else if (w_tick_up) begin
            reg_TCNT <= reg_TCNT + 8'd1;
        end else if (w_tick_dn) begin
            reg_TCNT <= reg_TCNT - 8'd1;
        end
    end

    // Wrap events: each pulses for one cycle after the edge where the count wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf_evt <= 1'b0;
            r_unf_evt <= 1'b0;
        end else begin
            r_ovf_evt <= w_tick_up && (reg_TCNT == 8'hFF);
            r_unf_evt <= w_tick_dn && (reg_TCNT == 8'h00);
        end
    end

    // Sticky flags: a pending event wins over a clear that arrives at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (r_ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
            if (r_unf_evt) begin
                underflow <= 1'b1;
            end else if (clr_underflow) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

module timer_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ena,
    input  logic [7:0] start_counter,
    input  logic       up_down,
    input  logic       load,
    input  logic       enable,
    input  logic       clr_overflow,
    input  logic       clr_underflow,
    output logic       overflow,
    output logic       underflow
);

    counter u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_ena       (clk_ena),
        .start_counter (start_counter),
        .up_down       (up_down),
        .load          (load),
        .enable        (enable),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
        .overflow      (overflow),
        .underflow     (underflow)
    );

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter. It drives directed stimulus, and a behavioural
// model follows the count in plain integer arithmetic. A compare process checks
// the DUT against the model on every falling edge. Hand-computed expectations
// at key points pin down the model itself.

module tb_timer_counter;

    logic       clk;
    logic       rst_n;
    logic       clk_ena;
    logic [7:0] start_counter;
    logic       up_down;
    logic       load;
    logic       enable;
    logic       clr_overflow;
    logic       clr_underflow;
    logic       overflow;
    logic       underflow;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    int m_cnt;
    bit m_ovf, m_unf;
    bit m_ovf_pend, m_unf_pend;

    timer_counter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_ena       (clk_ena),
        .start_counter (start_counter),
        .up_down       (up_down),
        .load          (load),
        .enable        (enable),
        .clr_overflow  (clr_overflow),
        .clr_underflow (clr_underflow),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: a wrap is recognised when the new count moves the "wrong" way,
    // and it reaches the flag one edge later.
    always @(posedge clk) begin
        int nxt;
        bit wrap_up, wrap_dn;
        if (!rst_n) begin
            m_cnt = 0; m_ovf = 0; m_unf = 0; m_ovf_pend = 0; m_unf_pend = 0;
        end else begin
            if (m_ovf_pend) m_ovf = 1; else if (clr_overflow) m_ovf = 0;
            if (m_unf_pend) m_unf = 1; else if (clr_underflow) m_unf = 0;
            wrap_up = 0;
            wrap_dn = 0;
            if (load) begin
                m_cnt = int'(start_counter);
            end else if (enable && clk_ena) begin
                nxt = up_down ? (m_cnt + 1) % 256 : (m_cnt + 255) % 256;
                wrap_up = up_down && (nxt < m_cnt);
                wrap_dn = !up_down && (nxt > m_cnt);
                m_cnt = nxt;
            end
            m_ovf_pend = wrap_up;
            m_unf_pend = wrap_dn;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_cnt", int'(dut.u_counter.reg_TCNT), m_cnt);
            chk("model_ovf", int'(overflow), int'(m_ovf));
            chk("model_unf", int'(underflow), int'(m_unf));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        clk_ena = 1;
        @(posedge clk);
        #1;
        clk_ena = 0;
    endtask

    initial begin
        rst_n = 0; clk_ena = 0; start_counter = 0; up_down = 1; load = 0;
        enable = 0; clr_overflow = 0; clr_underflow = 0;

        // Reset
        idle(5);
        cmp_en = 1;
        chk("rst_cnt", int'(dut.u_counter.reg_TCNT), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
        rst_n = 1;

        // Count up through a full revolution
        load = 1; start_counter = 8'h00; up_down = 1; enable = 1;
        idle(1);
        load = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            chk("up_cnt", int'(dut.u_counter.reg_TCNT), (i + 1) % 256);
            chk("up_ovf", int'(overflow), 0);
            chk("up_unf", int'(underflow), 0);
            if (i == 255) begin
                idle(1);
                chk("ovf_set", int'(overflow), 1);
                chk("ovf_set_unf", int'(underflow), 0);
                idle(2);
            end else begin
                idle(3);
            end
        end

        // Underflow while overflow stays set
        up_down = 0;
        tick();
        chk("dn_cnt", int'(dut.u_counter.reg_TCNT), 8'hFF);
        chk("dn_unf_edge", int'(underflow), 0);
        chk("dn_ovf_kept", int'(overflow), 1);
        idle(1);
        chk("unf_set", int'(underflow), 1);
        chk("both_ovf", int'(overflow), 1);

        // Independent clears
        clr_overflow = 1; idle(1); clr_overflow = 0;
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_ovf_unf_kept", int'(underflow), 1);
        clr_underflow = 1; idle(1); clr_underflow = 0;
        chk("clr_unf", int'(underflow), 0);

        // Load and enable gating
        load = 1; start_counter = 8'hFE; idle(1); load = 0;
        chk("load_fe", int'(dut.u_counter.reg_TCNT), 8'hFE);
        enable = 0;
        repeat (3) begin tick(); idle(1); end
        chk("gated_hold", int'(dut.u_counter.reg_TCNT), 8'hFE);
        up_down = 1; load = 1; start_counter = 8'hFF; idle(1); load = 0;
        idle(2);
        chk("load_ff_cnt", int'(dut.u_counter.reg_TCNT), 8'hFF);
        chk("load_ff_noovf", int'(overflow), 0);
        enable = 1;
        tick();
        chk("wrap_cnt", int'(dut.u_counter.reg_TCNT), 0);
        chk("wrap_ovf_edge", int'(overflow), 0);
        idle(1);
        chk("wrap_ovf", int'(overflow), 1);

        // Load at a boundary with a simultaneous tick: load wins, no event
        clr_overflow = 1; idle(1); clr_overflow = 0;
        load = 1; start_counter = 8'h00; up_down = 0; clk_ena = 1; idle(1);
        load = 0; clk_ena = 0;
        idle(2);
        chk("load_tick_cnt", int'(dut.u_counter.reg_TCNT), 0);
        chk("load_tick_nounf", int'(underflow), 0);

        // Event beats simultaneous clear
        up_down = 1; load = 1; start_counter = 8'hFF; idle(1); load = 0;
        tick();
        clr_overflow = 1; idle(1); clr_overflow = 0;
        chk("evt_beats_clr", int'(overflow), 1);
        clr_overflow = 1; idle(1); clr_overflow = 0;
        chk("clr_after", int'(overflow), 0);

        // Reset with an event pending
        up_down = 0; load = 1; start_counter = 8'h00; idle(1); load = 0;
        tick();
        rst_n = 0; idle(1); rst_n = 1;
        chk("rst_mid_cnt", int'(dut.u_counter.reg_TCNT), 0);
        chk("rst_mid_unf", int'(underflow), 0);
        idle(2);
        chk("rst_mid_unf_late", int'(underflow), 0);

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
